// File: rtl/adder_tb_pkg.sv
// adder_tb_pkg: shared widths, FSM state and adder vector record for the adder self-test
package adder_tb_pkg;
  localparam int ADDER_WIDTH = 6;
  localparam int SWEEP_COUNT = 2**(2*ADDER_WIDTH+1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [ADDER_WIDTH-1:0] x;
    logic [ADDER_WIDTH-1:0] y;
    logic                   cin;
    logic [ADDER_WIDTH:0]   s;
  } adder_vec_t;
endpackage

// File: rtl/adder_ref_model.sv
// adder_ref_model: combinational golden sum x+y+cin
// Ports: i_x, i_y operands; i_cin carry in; o_s WIDTH+1-bit sum.
module adder_ref_model #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_cin,
  output logic [WIDTH:0]   o_s
);
  assign o_s = {1'b0, i_x} + {1'b0, i_y} + {{WIDTH{1'b0}}, i_cin};
endmodule

// File: rtl/adder_result_checker.sv
// adder_result_checker: checks a sweep of adder tuples, counting sum errors and order errors
// Ports: clk/rst; start begins a run; in_valid/in_ready handshake the {in_x,in_y,in_cin,in_s}
// tuple; busy/done/pass report run status; err_count/vec_count/order_err are the results;
// ff_valid/ff_* hold the first failing tuple.
module adder_result_checker
  import adder_tb_pkg::*;
#(
  parameter int WIDTH        = ADDER_WIDTH,
  parameter int VECTOR_COUNT = 2**(2*WIDTH+1),
  parameter int CNT_W        = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  input  logic [WIDTH:0]   in_s,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic             order_err,
  output logic             ff_valid,
  output logic [WIDTH-1:0] ff_x,
  output logic [WIDTH-1:0] ff_y,
  output logic             ff_cin,
  output logic [WIDTH:0]   ff_s
);
  localparam int LW = 2*WIDTH+1;
  state_t           r_state;
  logic             r_pv;
  logic [WIDTH-1:0] r_x, r_y;
  logic             r_cin;
  logic [WIDTH:0]   r_s;
  logic [LW-1:0]    r_idx;
  logic [CNT_W-1:0] r_vec_count, r_err;
  logic             r_order_err, r_pass, r_ff_valid;
  logic [WIDTH-1:0] r_ff_x, r_ff_y;
  logic             r_ff_cin;
  logic [WIDTH:0]   r_ff_s;
  logic [WIDTH:0]   w_exp;
  logic             w_acc, w_mis, w_oerr;
  adder_ref_model #(.WIDTH(WIDTH)) u_ref (.i_x(r_x), .i_y(r_y), .i_cin(r_cin), .o_s(w_exp));
  assign in_ready = (r_state == RUN) && (r_vec_count < CNT_W'(VECTOR_COUNT));
  assign w_acc    = in_valid && in_ready;
  assign w_mis    = w_exp != r_s;
  // the sweep index of a tuple is its operands concatenated, so it must equal its accept index
  assign w_oerr   = {r_x, r_y, r_cin} != r_idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pv        <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_cin       <= 1'b0;
      r_s         <= '0;
      r_idx       <= '0;
      r_vec_count <= '0;
      r_err       <= '0;
      r_order_err <= 1'b0;
      r_pass      <= 1'b0;
      r_ff_valid  <= 1'b0;
      r_ff_x      <= '0;
      r_ff_y      <= '0;
      r_ff_cin    <= 1'b0;
      r_ff_s      <= '0;
    end else if (start && r_state != RUN) begin
      r_state     <= RUN;
      r_pv        <= 1'b0;
      r_vec_count <= '0;
      r_err       <= '0;
      r_order_err <= 1'b0;
      r_pass      <= 1'b0;
      r_ff_valid  <= 1'b0;
      r_ff_x      <= '0;
      r_ff_y      <= '0;
      r_ff_cin    <= 1'b0;
      r_ff_s      <= '0;
    end else if (r_state == RUN) begin
      r_pv <= w_acc;
      if (w_acc) begin
        r_vec_count <= r_vec_count + CNT_W'(1);
        r_x         <= in_x;
        r_y         <= in_y;
        r_cin       <= in_cin;
        r_s         <= in_s;
        r_idx       <= r_vec_count[LW-1:0];
      end
      if (r_pv) begin
        if (w_mis) begin
          r_err <= r_err + CNT_W'(r_err != '1);
          if (!r_ff_valid) begin
            r_ff_valid <= 1'b1;
            r_ff_x     <= r_x;
            r_ff_y     <= r_y;
            r_ff_cin   <= r_cin;
            r_ff_s     <= r_s;
          end
        end
        if (w_oerr) r_order_err <= 1'b1;
        // accepts stop at VECTOR_COUNT, so a retire with the count full is the last tuple
        if (r_vec_count == CNT_W'(VECTOR_COUNT)) begin
          r_state <= DONE;
          r_pass  <= (r_err == '0) && !w_mis && !r_order_err && !w_oerr;
        end
      end
    end
  end
  assign busy      = r_state == RUN;
  assign done      = r_state == DONE;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign vec_count = r_vec_count;
  assign order_err = r_order_err;
  assign ff_valid  = r_ff_valid;
  assign ff_x      = r_ff_x;
  assign ff_y      = r_ff_y;
  assign ff_cin    = r_ff_cin;
  assign ff_s      = r_ff_s;
endmodule

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
Receiving end of the adder verification interface. Consumes a stream of {X, Y, c_in, S} tuples captured at the prefix adder's ports and recomputes the expected sum. It counts mismatches, checks that vectors arrive in exhaustive sweep order, and captures the first failing vector. It is the synthesizable counterpart to the stimulus sweep, for on-chip self-test of the adder.

Parameters:
WIDTH, 6, operand width in bits; sum width is WIDTH+1.
VECTOR_COUNT, 2**(2*WIDTH+1) = 8192, number of vectors expected per run.
CNT_W, 14, width of the vector and error counters; must hold VECTOR_COUNT.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse that begins a run.
in_valid  in  1  tuple on in_* is valid.
in_ready  out  1  checker accepts the tuple this cycle.
in_x  in  WIDTH  operand X.
in_y  in  WIDTH  operand Y.
in_cin  in  1  carry in.
in_s  in  WIDTH+1  adder result S under test.
busy  out  1  high in RUN.
done  out  1  high in DONE.
pass  out  1  valid while done is high: err_count==0 and order_err==0.
err_count  out  CNT_W  number of sum mismatches; saturating.
vec_count  out  CNT_W  number of tuples accepted.
order_err  out  1  sticky; a tuple arrived out of sweep order.
ff_valid  out  1  a first-failure record has been captured.
ff_x, ff_y, ff_cin, ff_s  out  WIDTH, WIDTH, 1, WIDTH+1  first failing tuple.

Behaviour:
- Reset: FSM to IDLE. All outputs 0, including in_ready, busy, done, pass, both counters, order_err, ff_* and the pipeline valid bit.
- FSM IDLE:
  - start -> RUN.
  - Entering RUN clears the counters, order_err, ff_* and pass.
- FSM RUN:
  - in_ready = (vec_count < VECTOR_COUNT).
  - Accept = in_valid & in_ready. Each accept increments vec_count and registers the tuple into a single compare stage.
  - in_valid gaps are legal. Tuple contents are only sampled on accept.
- Compare stage, one cycle after accept:
  - expected = zero-extended in_x + in_y + in_cin, WIDTH+1 bits; no overflow is possible.
  - Mismatch (expected != s): err_count += 1, holding at 2**CNT_W-1.
  - First mismatch with ff_valid==0: load ff_* and set ff_valid. Later mismatches do not overwrite the record.
  - Order check: {x,y,cin} != accept index (vec_count value at accept, truncated to 2*WIDTH+1 bits) sets order_err. A tuple that is out of order but correctly summed is not a mismatch.
- RUN -> DONE on the edge that retires the compare of the VECTOR_COUNT-th tuple. Final counter updates, done and pass all become visible in the same cycle.
- in_ready drops the cycle after the last accept. Further in_valid is ignored.
- FSM DONE:
  - Outputs hold.
  - start -> RUN, which clears as above.
  - start while in RUN is ignored.
- rst mid-run: abandons the run immediately and discards the in-flight compare. No partial done is produced.
- Accept and retire in the same cycle (back-to-back): both counters update correctly; no bubble is required.

Decomposition:
- Shared package adder_tb_pkg:
  - Holds ADDER_WIDTH=6 and SWEEP_COUNT=2**(2*ADDER_WIDTH+1).
  - Holds the state enum {IDLE, RUN, DONE}.
  - Holds a packed struct adder_vec_t {x, y, cin, s}, reused by the stimulus generator.
- Sub-module adder_ref_model: combinational golden sum (x+y+cin). Instantiated in the compare stage and shared with other benches.

Test Plan:
- Correct sweep, in_valid held high, in_s = x+y+cin for i=0..8191 -> done 1 cycle after the last accept, vec_count=8192, err_count=0, order_err=0, pass=1, ff_valid=0.
- Same sweep with in_s forced to 7'h00 at i=5 (x=0, y=0b000010, cin=1) and at i=9 -> err_count=2, ff_valid=1, ff_x=0, ff_y=2, ff_cin=1, ff_s=0, pass=0.
- Swap tuples i=100 and i=101, both summed correctly -> order_err=1, err_count=0, pass=0.
- in_valid toggled every other cycle -> run completes in about 16384 cycles with the same counts as the correct sweep; in_ready low immediately after the 8192nd accept.
- rst pulse after 300 accepts, then start and a full correct sweep -> the first run leaves no trace; final vec_count=8192, pass=1.
- From DONE with err_count=2, pulse start and run a correct sweep -> counters and ff_* cleared on entry to RUN; final pass=1.
